elevator_dispatch_queue: RTL and testbench

ELEVATOR_DISPATCH_QUEUE -- requirements
Module: elevator_dispatch_queue

---
 rtl/elevator_pkg.sv | 12 +
 rtl/elevator_floor_search.sv | 38 +++
 rtl/elevator_dispatch_queue.sv | 119 +++++++++++
 tb/tb_elevator_dispatch_queue.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator dispatch queue.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } dir_t;

    localparam int DEFAULT_FLOOR_COUNT = 7;

endpackage

// File: rtl/elevator_floor_search.sv
// Scans the pending-floor bitmap for the nearest requests above and below
// the car.
module elevator_floor_search
    import elevator_pkg::*;
#(
    parameter int FLOOR_COUNT = DEFAULT_FLOOR_COUNT,
    parameter int FLOOR_W     = $clog2(FLOOR_COUNT)
) (
    input  logic [FLOOR_COUNT-1:0] i_bitmap,
    input  logic [FLOOR_W-1:0]     i_floor,
    output logic                   o_anyAbove,
    output logic                   o_anyBelow,
    output logic [FLOOR_W-1:0]     o_nearestAbove,
    output logic [FLOOR_W-1:0]     o_nearestBelow
);

    // Downward scan so the last hit above is the lowest; upward scan so the
    // last hit below is the highest.
    always_comb begin
        o_anyAbove     = 1'b0;
        o_anyBelow     = 1'b0;
        o_nearestAbove = '0;
        o_nearestBelow = '0;
        for (int i = FLOOR_COUNT - 1; i >= 0; i--) begin
            if (i_bitmap[i] && (i > int'(i_floor))) begin
                o_anyAbove     = 1'b1;
                o_nearestAbove = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < FLOOR_COUNT; i++) begin
            if (i_bitmap[i] && (i < int'(i_floor))) begin
                o_anyBelow     = 1'b1;
                o_nearestBelow = FLOOR_W'(i);
            end
        end
    end

endmodule

// File: rtl/elevator_dispatch_queue.sv
// Pending-floor queue plus the IDLE/UP/DOWN direction FSM that picks the
// next stop for the car.
module elevator_dispatch_queue
    import elevator_pkg::*;
#(
    parameter int FLOOR_COUNT = DEFAULT_FLOOR_COUNT,
    parameter int FLOOR_W     = $clog2(FLOOR_COUNT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [FLOOR_W-1:0]     req_floor,
    input  logic                   req_cancel,
    input  logic [FLOOR_W-1:0]     current_floor,
    input  logic                   arrived,
    output logic [FLOOR_COUNT-1:0] queue_status,
    output logic                   target_valid,
    output logic [FLOOR_W-1:0]     target_floor,
    output logic [1:0]             direction,
    output logic                   req_error
);

    logic [FLOOR_COUNT-1:0] r_queue;
    dir_t                   r_dir;
    logic [FLOOR_W-1:0]     r_target;
    logic                   r_targetValid;
    logic                   r_reqError;

    logic [FLOOR_W-1:0]     w_curFloor;
    logic [FLOOR_COUNT-1:0] w_curMask;
    logic [FLOOR_COUNT-1:0] w_reqMask;
    logic                   w_reqInRange;
    logic                   w_anyAbove;
    logic                   w_anyBelow;
    logic [FLOOR_W-1:0]     w_nearestAbove;
    logic [FLOOR_W-1:0]     w_nearestBelow;
    logic                   w_onlyCur;
    logic                   w_clearCur;
    logic [FLOOR_COUNT-1:0] w_nextQueue;

    // An out-of-range car position is treated as the top floor.
    assign w_curFloor   = (int'(current_floor) > FLOOR_COUNT - 1)
                          ? FLOOR_W'(FLOOR_COUNT - 1) : current_floor;
    assign w_reqInRange = int'(req_floor) < FLOOR_COUNT;
    assign w_curMask    = FLOOR_COUNT'(1) << w_curFloor;
    assign w_reqMask    = FLOOR_COUNT'(1) << req_floor;

    elevator_floor_search #(
        .FLOOR_COUNT(FLOOR_COUNT),
        .FLOOR_W    (FLOOR_W)
    ) u_search (
        .i_bitmap      (r_queue),
        .i_floor       (w_curFloor),
        .o_anyAbove    (w_anyAbove),
        .o_anyBelow    (w_anyBelow),
        .o_nearestAbove(w_nearestAbove),
        .o_nearestBelow(w_nearestBelow)
    );

    // An idle car already sitting at its only pending floor services it in place.
    assign w_onlyCur  = ((r_queue & w_curMask) != '0) && !w_anyAbove && !w_anyBelow;
    assign w_clearCur = arrived || ((r_dir == IDLE) && w_onlyCur);

    always_comb begin
        w_nextQueue = r_queue;
        if (w_clearCur) begin
            w_nextQueue = w_nextQueue & ~w_curMask;
        end
        if (req_valid && w_reqInRange) begin
            if (req_cancel) begin
                w_nextQueue = w_nextQueue & ~w_reqMask;
            end else if (!(w_clearCur && (req_floor == w_curFloor))) begin
                w_nextQueue = w_nextQueue | w_reqMask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_queue    <= '0;
            r_reqError <= 1'b0;
        end else begin
            r_queue    <= w_nextQueue;
            r_reqError <= req_valid && !w_reqInRange;
        end
    end

    // DOWN keeps going while anything is below; every other case prefers UP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dir         <= IDLE;
            r_target      <= '0;
            r_targetValid <= 1'b0;
        end else if ((r_dir == DOWN) && w_anyBelow) begin
            r_dir         <= DOWN;
            r_target      <= w_nearestBelow;
            r_targetValid <= 1'b1;
        end else if (w_anyAbove) begin
            r_dir         <= UP;
            r_target      <= w_nearestAbove;
            r_targetValid <= 1'b1;
        end else if (w_anyBelow) begin
            r_dir         <= DOWN;
            r_target      <= w_nearestBelow;
            r_targetValid <= 1'b1;
        end else begin
            r_dir         <= IDLE;
            r_target      <= w_curFloor;
            r_targetValid <= 1'b0;
        end
    end

    assign queue_status = r_queue;
    assign direction    = r_dir;
    assign target_floor = r_target;
    assign target_valid = r_targetValid;
    assign req_error    = r_reqError;

endmodule

// File: tb/tb_elevator_dispatch_queue.sv
// Directed scenarios plus a randomized run against a floor-by-floor model
// of the dispatch rules.
module tb_elevator_dispatch_queue;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic [2:0] req_floor;
    logic       req_cancel;
    logic [2:0] current_floor;
    logic       arrived;
    logic [6:0] queue_status;
    logic       target_valid;
    logic [2:0] target_floor;
    logic [1:0] direction;
    logic       req_error;

    logic [13:0] obs;
    int total = 0;
    int bad   = 0;

    // Model state: one flag per floor, direction 0=idle 1=up 2=down.
    bit mPend[7];
    int mDir;
    int mTarget;
    bit mErr;

    elevator_dispatch_queue #(.FLOOR_COUNT(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_floor    (req_floor),
        .req_cancel   (req_cancel),
        .current_floor(current_floor),
        .arrived      (arrived),
        .queue_status (queue_status),
        .target_valid (target_valid),
        .target_floor (target_floor),
        .direction    (direction),
        .req_error    (req_error)
    );

    assign obs = {queue_status, direction, target_valid, target_floor, req_error};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        req_valid  = 1'b0;
        req_cancel = 1'b0;
        req_floor  = 3'd0;
        arrived    = 1'b0;
    endtask

    task automatic request(input logic [2:0] f, input logic c);
        req_valid  = 1'b1;
        req_floor  = f;
        req_cancel = c;
    endtask

    task automatic test_reset();
        idleInputs();
        current_floor = 3'd0;
        reset = 1'b0;
        tick();
        tick();
        total++;
        if (obs !== {7'b0000000, 2'd0, 1'b0, 3'd0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_held: got %b want %b", obs, {7'b0, 2'd0, 1'b0, 3'd0, 1'b0});
        end
        reset = 1'b1;
        tick();
        total++;
        if (obs !== {7'b0000000, 2'd0, 1'b0, 3'd0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_release: got %b want %b", obs, {7'b0, 2'd0, 1'b0, 3'd0, 1'b0});
        end
    endtask

    task automatic test_request_up();
        current_floor = 3'd0;
        request(3'd5, 1'b0);
        tick();
        idleInputs();
        total++;
        if (obs !== {7'b0100000, 2'd0, 1'b0, 3'd0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL req5_queue: got %b want %b", obs, {7'b0100000, 2'd0, 1'b0, 3'd0, 1'b0});
        end
        tick();
        total++;
        if (obs !== {7'b0100000, 2'd1, 1'b1, 3'd5, 1'b0}) begin
            bad++;
            $display("[TB] FAIL req5_target: got %b want %b", obs, {7'b0100000, 2'd1, 1'b1, 3'd5, 1'b0});
        end
    endtask

    task automatic test_arrive_reverse();
        current_floor = 3'd3;
        request(3'd1, 1'b0);
        tick();
        idleInputs();
        tick();
        total++;
        if (obs !== {7'b0100010, 2'd1, 1'b1, 3'd5, 1'b0}) begin
            bad++;
            $display("[TB] FAIL pending51_up: got %b want %b", obs, {7'b0100010, 2'd1, 1'b1, 3'd5, 1'b0});
        end
        current_floor = 3'd5;
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        total++;
        if (obs !== {7'b0000010, 2'd2, 1'b1, 3'd1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL arrive5_down: got %b want %b", obs, {7'b0000010, 2'd2, 1'b1, 3'd1, 1'b0});
        end
        tick();
        total++;
        if (obs !== {7'b0000010, 2'd2, 1'b1, 3'd1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL arrive5_hold: got %b want %b", obs, {7'b0000010, 2'd2, 1'b1, 3'd1, 1'b0});
        end
    endtask

    task automatic test_arrive_collision();
        request(3'd2, 1'b0);
        tick();
        total++;
        if (obs !== {7'b0000110, 2'd2, 1'b1, 3'd1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL set2: got %b want %b", obs, {7'b0000110, 2'd2, 1'b1, 3'd1, 1'b0});
        end
        current_floor = 3'd2;
        arrived = 1'b1;
        request(3'd6, 1'b0);
        tick();
        total++;
        if (obs !== {7'b1000010, 2'd2, 1'b1, 3'd1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL req6_arrive2: got %b want %b", obs, {7'b1000010, 2'd2, 1'b1, 3'd1, 1'b0});
        end
        request(3'd2, 1'b0);
        tick();
        idleInputs();
        total++;
        if (obs !== {7'b1000010, 2'd2, 1'b1, 3'd1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL req2_arrive2: got %b want %b", obs, {7'b1000010, 2'd2, 1'b1, 3'd1, 1'b0});
        end
    endtask

    task automatic test_error();
        request(3'd7, 1'b0);
        tick();
        idleInputs();
        total++;
        if (obs !== {7'b1000010, 2'd2, 1'b1, 3'd1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL err_pulse: got %b want %b", obs, {7'b1000010, 2'd2, 1'b1, 3'd1, 1'b1});
        end
        tick();
        total++;
        if (obs !== {7'b1000010, 2'd2, 1'b1, 3'd1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL err_clear: got %b want %b", obs, {7'b1000010, 2'd2, 1'b1, 3'd1, 1'b0});
        end
    endtask

    task automatic test_cancel();
        idleInputs();
        current_floor = 3'd0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        request(3'd4, 1'b0);
        tick();
        idleInputs();
        tick();
        total++;
        if (obs !== {7'b0010000, 2'd1, 1'b1, 3'd4, 1'b0}) begin
            bad++;
            $display("[TB] FAIL pending4_up: got %b want %b", obs, {7'b0010000, 2'd1, 1'b1, 3'd4, 1'b0});
        end
        request(3'd4, 1'b1);
        tick();
        idleInputs();
        total++;
        if (obs !== {7'b0000000, 2'd1, 1'b1, 3'd4, 1'b0}) begin
            bad++;
            $display("[TB] FAIL cancel4_queue: got %b want %b", obs, {7'b0, 2'd1, 1'b1, 3'd4, 1'b0});
        end
        tick();
        total++;
        if (obs !== {7'b0000000, 2'd0, 1'b0, 3'd0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL cancel4_idle: got %b want %b", obs, {7'b0, 2'd0, 1'b0, 3'd0, 1'b0});
        end
    endtask

    task automatic test_idle_current();
        current_floor = 3'd3;
        request(3'd3, 1'b0);
        tick();
        idleInputs();
        total++;
        if (obs !== {7'b0001000, 2'd0, 1'b0, 3'd3, 1'b0}) begin
            bad++;
            $display("[TB] FAIL here_set: got %b want %b", obs, {7'b0001000, 2'd0, 1'b0, 3'd3, 1'b0});
        end
        tick();
        total++;
        if (obs !== {7'b0000000, 2'd0, 1'b0, 3'd3, 1'b0}) begin
            bad++;
            $display("[TB] FAIL here_clear: got %b want %b", obs, {7'b0, 2'd0, 1'b0, 3'd3, 1'b0});
        end
    endtask

    task automatic test_clamp();
        current_floor = 3'd7;
        request(3'd2, 1'b0);
        tick();
        total++;
        if (obs !== {7'b0000100, 2'd0, 1'b0, 3'd6, 1'b0}) begin
            bad++;
            $display("[TB] FAIL clamp_idle: got %b want %b", obs, {7'b0000100, 2'd0, 1'b0, 3'd6, 1'b0});
        end
        request(3'd6, 1'b0);
        tick();
        idleInputs();
        total++;
        if (obs !== {7'b1000100, 2'd2, 1'b1, 3'd2, 1'b0}) begin
            bad++;
            $display("[TB] FAIL clamp_down: got %b want %b", obs, {7'b1000100, 2'd2, 1'b1, 3'd2, 1'b0});
        end
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        total++;
        if (obs !== {7'b0000100, 2'd2, 1'b1, 3'd2, 1'b0}) begin
            bad++;
            $display("[TB] FAIL clamp_arrive: got %b want %b", obs, {7'b0000100, 2'd2, 1'b1, 3'd2, 1'b0});
        end
    endtask

    task automatic test_midreset();
        reset = 1'b0;
        request(3'd1, 1'b0);
        tick();
        total++;
        if (obs !== {7'b0000000, 2'd0, 1'b0, 3'd0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL midreset: got %b want %b", obs, {7'b0, 2'd0, 1'b0, 3'd0, 1'b0});
        end
        reset = 1'b1;
        idleInputs();
        tick();
        total++;
        if (obs !== {7'b0000000, 2'd0, 1'b0, 3'd6, 1'b0}) begin
            bad++;
            $display("[TB] FAIL midreset_after: got %b want %b", obs, {7'b0, 2'd0, 1'b0, 3'd6, 1'b0});
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int cf;
        int nAbove;
        int nBelow;
        int cnt;
        int nd;
        int rf;
        bit clr;
        bit newPend[7];
        if (!reset) begin
            for (int f = 0; f < 7; f++) mPend[f] = 1'b0;
            mDir = 0;
            mTarget = 0;
            mErr = 1'b0;
            return;
        end
        cf = (int'(current_floor) > 6) ? 6 : int'(current_floor);
        rf = int'(req_floor);
        nAbove = -1;
        nBelow = -1;
        cnt = 0;
        for (int f = 0; f < 7; f++) begin
            if (mPend[f]) begin
                cnt++;
                if (f > cf && nAbove < 0) nAbove = f;
                if (f < cf) nBelow = f;
            end
        end
        case (mDir)
            2:       nd = (nBelow >= 0) ? 2 : (nAbove >= 0) ? 1 : 0;
            1:       nd = (nAbove >= 0) ? 1 : (nBelow >= 0) ? 2 : 0;
            default: nd = (nAbove >= 0) ? 1 : (nBelow >= 0) ? 2 : 0;
        endcase
        mTarget = (nd == 1) ? nAbove : (nd == 2) ? nBelow : cf;
        clr = arrived || (mDir == 0 && cnt == 1 && mPend[cf]);
        newPend = mPend;
        if (clr) newPend[cf] = 1'b0;
        if (req_valid && rf < 7) begin
            if (req_cancel) newPend[rf] = 1'b0;
            else if (!(clr && rf == cf)) newPend[rf] = 1'b1;
        end
        mErr = req_valid && (rf >= 7);
        mPend = newPend;
        mDir = nd;
    endtask

    task automatic test_random();
        logic [6:0]  expQ;
        logic [13:0] expV;
        for (int i = 0; i < 800; i++) begin
            reset         = (i == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
            req_valid     = ($urandom_range(0, 1) != 0);
            req_floor     = 3'($urandom_range(0, 7));
            req_cancel    = ($urandom_range(0, 3) == 0);
            current_floor = 3'($urandom_range(0, 7));
            arrived       = ($urandom_range(0, 3) == 0);
            model_step();
            tick();
            for (int f = 0; f < 7; f++) expQ[f] = mPend[f];
            expV = {expQ, 2'(mDir), (mDir != 0), 3'(mTarget), mErr};
            total++;
            if (obs !== expV) begin
                bad++;
                $display("[TB] FAIL random cycle %0d: got %b want %b", i, obs, expV);
            end
        end
        idleInputs();
    endtask

    initial begin
        idleInputs();
        reset = 1'b0;
        current_floor = 3'd0;
        test_reset();
        test_request_up();
        test_arrive_reverse();
        test_arrive_collision();
        test_error();
        test_cancel();
        test_idle_current();
        test_clamp();
        test_midreset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
